// File: rtl/inbuf_mcast.sv
// Per-input-port router flit buffer with multicast replication: the head flit
// stays until every output in its mask has been granted, then frees one credit.
module inbuf_mcast #(
    parameter int FLIT_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic [4:0]        in_mask,
    output logic [4:0]        req,
    input  logic [4:0]        grt,
    output logic [FLIT_W-1:0] out_flit,
    output logic              credit_ret,
    output logic [CNT_W-1:0]  count,
    output logic              ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [4:0]        r_mask_mem [DEPTH];
    logic [FLIT_W-1:0] r_flit_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [4:0]        r_served;
    logic              r_credit;
    logic              r_ovf;

    logic              w_nonempty;
    logic              w_full;
    logic [4:0]        w_pending;
    logic [4:0]        w_req;
    logic [4:0]        w_hit;
    logic              w_pop;
    logic              w_in_ok;
    logic              w_discard;
    logic              w_push;
    logic              w_drop;

    // Head request/grant bookkeeping and push/pop decisions for this cycle
    always_comb begin
        w_nonempty = (r_count != {CNT_W{1'b0}});
        w_full     = (r_count == CNT_W'(DEPTH));
        w_pending  = r_mask_mem[r_rd_ptr] & ~r_served;
        if (w_nonempty) begin
            w_req = w_pending;
        end else begin
            w_req = 5'b00000;
        end
        // Grants on outputs we are not requesting are ignored
        w_hit     = grt & w_req;
        w_pop     = (w_hit != 5'b00000) && ((w_pending & ~w_hit) == 5'b00000);
        w_in_ok   = in_valid && (in_mask != 5'b00000);
        w_discard = in_valid && (in_mask == 5'b00000);
        w_push    = w_in_ok && (!w_full || w_pop);
        w_drop    = w_in_ok && w_full && !w_pop;
    end

    // Flit storage; contents are don't-care after reset so no reset is applied
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mask_mem[r_wr_ptr] <= in_mask;
            r_flit_mem[r_wr_ptr] <= in_flit;
        end
    end

    // Pointers, occupancy, partial-grant tracking, credit and overflow flag
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_served <= 5'b00000;
            r_credit <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_served <= 5'b00000;
            end else begin
                r_served <= r_served | w_hit;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A pop and a zero-mask discard in one cycle share a single pulse
            r_credit <= w_pop | w_discard;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Head outputs derive from registered state so reset clears them at once
    always_comb begin
        req = w_req;
        if (w_nonempty) begin
            out_flit = r_flit_mem[r_rd_ptr];
        end else begin
            out_flit = {FLIT_W{1'b0}};
        end
    end

    assign credit_ret = r_credit;
    assign count      = r_count;
    assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_inbuf_mcast.sv
// Self-checking bench for inbuf_mcast: directed scenarios plus random traffic
// compared against a queue-based model of the multicast buffer.
module tb_inbuf_mcast;

    localparam int FLIT_W = 64;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic              in_valid = 1'b0;
    logic [FLIT_W-1:0] in_flit = 64'd0;
    logic [4:0]        in_mask = 5'd0;
    logic [4:0]        grt = 5'd0;
    logic [4:0]        req;
    logic [FLIT_W-1:0] out_flit;
    logic              credit_ret;
    logic [CNT_W-1:0]  count;
    logic              ovf_err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [4:0]        mask;
        logic [FLIT_W-1:0] flit;
    } ent_t;

    ent_t       q[$];
    logic [4:0] m_served = 5'd0;
    logic       m_credit = 1'b0;
    logic       m_ovf    = 1'b0;

    inbuf_mcast #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_flit(in_flit),
        .in_mask(in_mask), .req(req), .grt(grt), .out_flit(out_flit),
        .credit_ret(credit_ret), .count(count), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    function automatic logic [4:0] exp_req();
        if (q.size() != 0) return q[0].mask & ~m_served;
        return 5'd0;
    endfunction

    function automatic logic [FLIT_W-1:0] exp_flit();
        if (q.size() != 0) return q[0].flit;
        return 64'd0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_served = 5'd0;
        m_credit = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // One clock cycle: apply inputs, update the model at the edge, idle at negedge
    task automatic drive_cycle(input logic v, input logic [FLIT_W-1:0] f,
                               input logic [4:0] m, input logic [4:0] g);
        logic [4:0] pend, hit;
        logic       pop, full;
        ent_t       e;
        in_valid = v; in_flit = f; in_mask = m; grt = g;
        @(posedge clk);
        pend = exp_req();
        hit  = g & pend;
        pop  = (hit != 5'd0) && ((pend & ~hit) == 5'd0);
        full = (q.size() == DEPTH);
        m_credit = pop || (v && m == 5'd0);
        if (pop) begin
            e = q.pop_front();
            m_served = 5'd0;
        end else begin
            m_served = m_served | hit;
        end
        if (v && m != 5'd0) begin
            if (!full || pop) begin
                e.mask = m; e.flit = f;
                q.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_flit = 64'd0; in_mask = 5'd0; grt = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ = 1'b0;
        model_reset();
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        model_reset();
        #3;
        n_cmp++; if (req !== 5'd0 || count !== 3'd0) begin n_fail++;
            $display("FAIL reset_hold: req=%b count=%0d required 0/0", req, count); end
        @(negedge clk);
        rst_ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 64'd0, 5'd0, 5'b11111);
            n_cmp++; if (req !== 5'd0) begin n_fail++;
                $display("FAIL reset_req: got %b required 00000", req); end
            n_cmp++; if (count !== 3'd0) begin n_fail++;
                $display("FAIL reset_count: got %0d required 0", count); end
            n_cmp++; if (credit_ret !== 1'b0) begin n_fail++;
                $display("FAIL reset_credit: got %b required 0", credit_ret); end
            n_cmp++; if (out_flit !== 64'd0 || ovf_err !== 1'b0) begin n_fail++;
                $display("FAIL reset_flit: got %h ovf=%b required 0", out_flit, ovf_err); end
        end
    endtask

    task automatic test_unicast();
        logic [FLIT_W-1:0] a;
        a = {$urandom, $urandom};
        drive_cycle(1'b1, a, 5'b00100, 5'd0);
        n_cmp++; if (req !== 5'b00100 || count !== 3'd1 || out_flit !== a) begin n_fail++;
            $display("FAIL uni_push: req=%b count=%0d flit=%h required 00100/1/%h", req, count, out_flit, a); end
        n_cmp++; if (credit_ret !== 1'b0) begin n_fail++;
            $display("FAIL uni_nocredit: got %b required 0", credit_ret); end
        drive_cycle(1'b0, 64'd0, 5'd0, 5'b00100);
        n_cmp++; if (req !== 5'd0 || count !== 3'd0 || credit_ret !== 1'b1) begin n_fail++;
            $display("FAIL uni_pop: req=%b count=%0d credit=%b required 00000/0/1", req, count, credit_ret); end
        drive_cycle(1'b0, 64'd0, 5'd0, 5'd0);
        n_cmp++; if (credit_ret !== 1'b0) begin n_fail++;
            $display("FAIL uni_pulse: credit=%b required 0", credit_ret); end
    endtask

    task automatic test_multicast();
        logic [4:0] g_seq [4];
        logic [4:0] r_seq [4];
        g_seq[0] = 5'b00001; r_seq[0] = 5'b10010;
        g_seq[1] = 5'b01000; r_seq[1] = 5'b10010;
        g_seq[2] = 5'b10000; r_seq[2] = 5'b00010;
        g_seq[3] = 5'b00010; r_seq[3] = 5'b00000;
        drive_cycle(1'b1, 64'hB0B0_1234_5678_9ABC, 5'b10011, 5'd0);
        n_cmp++; if (req !== 5'b10011) begin n_fail++;
            $display("FAIL mc_head: req=%b required 10011", req); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 64'd0, 5'd0, g_seq[i]);
            n_cmp++; if (req !== r_seq[i]) begin n_fail++;
                $display("FAIL mc_req%0d: req=%b required %b", i, req, r_seq[i]); end
            n_cmp++; if (credit_ret !== (i == 3) || count !== ((i == 3) ? 3'd0 : 3'd1)) begin n_fail++;
                $display("FAIL mc_state%0d: credit=%b count=%0d", i, credit_ret, count); end
        end
        drive_cycle(1'b0, 64'd0, 5'd0, 5'd0);
        n_cmp++; if (credit_ret !== 1'b0) begin n_fail++;
            $display("FAIL mc_pulse: credit=%b required 0", credit_ret); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, {$urandom, $urandom}, 5'($urandom_range(1, 31)), 5'b11111);
            n_cmp++; if (count !== 3'd1 || credit_ret !== (i != 0)) begin n_fail++;
                $display("FAIL b2b%0d: count=%0d credit=%b required 1/%b", i, count, credit_ret, i != 0); end
            n_cmp++; if (out_flit !== exp_flit() || req !== exp_req()) begin n_fail++;
                $display("FAIL b2b_head%0d: flit=%h req=%b required %h/%b", i, out_flit, req, exp_flit(), exp_req()); end
        end
        drive_cycle(1'b0, 64'd0, 5'd0, 5'b11111);
        n_cmp++; if (count !== 3'd0 || credit_ret !== 1'b1) begin n_fail++;
            $display("FAIL b2b_drain: count=%0d credit=%b required 0/1", count, credit_ret); end
    endtask

    task automatic test_overflow();
        logic [FLIT_W-1:0] f [5];
        logic [4:0]        m [5];
        for (int i = 0; i < 5; i++) begin
            f[i] = {$urandom, $urandom};
            m[i] = 5'($urandom_range(1, 31));
            drive_cycle(1'b1, f[i], m[i], 5'd0);
        end
        n_cmp++; if (count !== 3'd4 || ovf_err !== 1'b1) begin n_fail++;
            $display("FAIL ovf_full: count=%0d ovf=%b required 4/1", count, ovf_err); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_flit !== f[k] || req !== m[k]) begin n_fail++;
                $display("FAIL ovf_order%0d: flit=%h req=%b required %h/%b", k, out_flit, req, f[k], m[k]); end
            drive_cycle(1'b0, 64'd0, 5'd0, m[k]);
            n_cmp++; if (credit_ret !== 1'b1 || ovf_err !== 1'b1 || count !== 3'(3 - k)) begin n_fail++;
                $display("FAIL ovf_drain%0d: credit=%b ovf=%b count=%0d", k, credit_ret, ovf_err, count); end
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, {$urandom, $urandom}, 5'($urandom_range(1, 31)), 5'd0);
        for (int i = 0; i < 12; i++) begin
            n_cmp++; if (out_flit !== exp_flit()) begin n_fail++;
                $display("FAIL fpp_head%0d: flit=%h required %h", i, out_flit, exp_flit()); end
            drive_cycle(1'b1, {$urandom, $urandom}, 5'($urandom_range(1, 31)), exp_req());
            n_cmp++; if (count !== 3'd4 || ovf_err !== 1'b0 || credit_ret !== 1'b1) begin n_fail++;
                $display("FAIL fpp%0d: count=%0d ovf=%b credit=%b required 4/0/1", i, count, ovf_err, credit_ret); end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_flit !== exp_flit() || req !== exp_req()) begin n_fail++;
                $display("FAIL fpp_drain%0d: flit=%h req=%b required %h/%b", i, out_flit, req, exp_flit(), exp_req()); end
            drive_cycle(1'b0, 64'd0, 5'd0, 5'b11111);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 64'hC0DE_C0DE_C0DE_C0DE, 5'b11000, 5'd0);
        drive_cycle(1'b0, 64'd0, 5'd0, 5'b01000);
        n_cmp++; if (req !== 5'b10000) begin n_fail++;
            $display("FAIL ar_partial: req=%b required 10000", req); end
        #2;
        rst_ = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (req !== 5'd0 || count !== 3'd0 || out_flit !== 64'd0) begin n_fail++;
            $display("FAIL ar_immediate: req=%b count=%0d flit=%h required 0", req, count, out_flit); end
        @(negedge clk);
        rst_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 64'd0, 5'd0, 5'b11111);
            n_cmp++; if (credit_ret !== 1'b0 || count !== 3'd0) begin n_fail++;
                $display("FAIL ar_after%0d: credit=%b count=%0d required 0/0", i, credit_ret, count); end
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [4:0] m;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            v = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive_cycle(v, {$urandom, $urandom}, m, 5'($urandom));
            n_cmp++; if (req !== exp_req() || out_flit !== exp_flit()) begin n_fail++;
                $display("FAIL rnd_head%0d: req=%b flit=%h required %b/%h", i, req, out_flit, exp_req(), exp_flit()); end
            n_cmp++; if (count !== CNT_W'(q.size()) || credit_ret !== m_credit || ovf_err !== m_ovf) begin n_fail++;
                $display("FAIL rnd_state%0d: count=%0d credit=%b ovf=%b required %0d/%b/%b",
                         i, count, credit_ret, ovf_err, q.size(), m_credit, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_multicast();
        test_back_to_back();
        test_overflow();
        test_full_pushpop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inbuf_mcast.md
# inbuf_mcast

Per-input-port flit buffer of the router, one instance per input (E, S, W, N, Eject-side inject). It stores incoming flits, each tagged with its destination output-port mask from the node-table lookup. It drives the head flit's pending output requests into the five per-output fixed-priority arbiters and collects their grants. A flit is popped only once every output in its mask has been granted, which gives multicast replication with partial-grant tracking, and a credit is returned upstream per freed slot.

## Interface
- FLIT_W, 64, payload width of one flit
- DEPTH, 4, buffer entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), occupancy counter width
- clk  input  1  router clock, all state on rising edge
- rst_  input  1  asynchronous, active-low reset
- in_valid  input  1  flit present on in_flit/in_mask this cycle
- in_flit  input  FLIT_W  incoming payload
- in_mask  input  `PORT+1 (5)  requested output ports, bit order as arbiter (0..4)
- req  output  5  req[o]: head flit still needs output o; goes to arbiter of output o
- grt  input  5  grt[o]: arbiter of output o granted this input this cycle
- out_flit  output  FLIT_W  head payload to crossbar
- credit_ret  output  1  one-cycle pulse per slot freed
- count  output  CNT_W  current occupancy
- ovf_err  output  1  sticky: write attempted while full without a same-cycle pop

## Operation
- Circular storage: mem[DEPTH] of {mask, flit}, wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap), count.
- Enqueue: in_valid and in_mask != 0 → write at wr_ptr, wr_ptr+1, count+1.
- Zero-mask flit: discarded and never stored. credit_ret pulses next cycle as if stored and freed.
- Head state: served[4:0] register.
  - pending = mem[rd_ptr].mask & ~served.
  - req = (count != 0) ? pending : 0.
  - out_flit = (count != 0) ? mem[rd_ptr].flit : 0.
- Grant acceptance: hit = grt & req. Grant bits where req is 0 are ignored.
- Done condition: (pending & ~hit) == 0 and hit != 0.
  - Done → pop at the edge: rd_ptr+1, count−1, served←0, credit_ret=1 next cycle.
  - Otherwise served ← served | hit; head stays.
- A masked (contention-blocked) output simply returns grt[o]=0. The block keeps requesting indefinitely, with no timeout.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push when full (count==DEPTH), no pop same cycle: flit dropped, ovf_err←1 until reset.
- Push when full with pop same cycle: accepted.
- credit_ret is a single registered bit, one pulse per pop or zero-mask discard. A pop and a zero-mask discard in the same cycle cannot both be credited by one bit. Upstream must never send a zero-mask flit; the first pulse covers the pop and the discard's credit is lost. The verifier flags this as an upstream protocol error.

## Timing
- Reset (rst_ low, async) values:
  - req=0, out_flit=0, credit_ret=0, count=0, ovf_err=0
  - pointers=0, served=0
  - mem contents don't-care
- Reset asserted mid-multicast: partially served head flit is lost; no credit_ret issued for it.
- Write latency: flit accepted at edge N into empty buffer → req and out_flit valid from cycle N+1. No bypass.
- Grant to pop: single-output flit granted in cycle N → popped at edge ending N. The next head's req is visible in N+1.
- Multicast: served bits update at each grant edge. Grants may arrive in any order and in any cycles, including all five in one cycle (single-cycle pop).
- credit_ret: asserted exactly the cycle after the pop or discard edge, for one cycle.
- Throughput: one flit per cycle in and out when every head flit gets all its grants in one cycle.

## Test plan
- Reset/empty: release rst_, in_valid=0, grt=5'b11111 → req=0, count=0, credit_ret=0, out_flit=0 for 10 cycles.
- Unicast: push A (mask 5'b00100) at edge 1; grt=5'b00100 in cycle 2.
  - req=5'b00100 in cycle 2 only.
  - credit_ret=1 in cycle 3.
  - count 1→0.
- Multicast partial grants: push B (mask 5'b10011); grants in order, one grant per cycle:
  - grt=5'b00001 → req becomes 5'b10010
  - grt=5'b10000 → req becomes 5'b00010
  - grt=5'b00010 → pop; credit_ret one cycle later
  - Stray grt=5'b01000 mid-sequence is ignored.
- Full/overflow: DEPTH=4, no grants, push 5 flits.
  - count=4.
  - 5th flit dropped; ovf_err=1 and stays 1.
  - Then grant all four in order: payloads exit in FIFO order, 4 credit pulses.
- Full with simultaneous push/pop: count=4, head granted and new push in same cycle → accepted, count stays 4, ovf_err=0, pointers wrap correctly over 3 laps.
- Async reset mid-multicast: head mask 5'b11000 with served=5'b01000; assert rst_ between edges → req=0 and count=0 immediately, no credit_ret after release.
